// File: rtl/mouse_shot_ctl.sv
// mouse_shot_ctl: cursor clamp plus debounced, handshaked shot generator.
// Optional macro SHOT_COUNTER_EN enables the saturating accepted-shot counter.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   xpos_in, ypos_in      cursor position (already in clk domain)
//   left_in               raw left button (asynchronous)
//   xpos_out, ypos_out    clamped, registered cursor position
//   shot_valid/ready      shot handshake; shot_x/shot_y carry the shot position
//   shot_count            accepted shots (tied to zero without SHOT_COUNTER_EN)

module mouse_shot_ctl #(
    parameter int unsigned SCREEN_W        = 1024,
    parameter int unsigned SCREEN_H        = 768,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned COOLDOWN_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        left_in,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        shot_valid,
    output logic [11:0] shot_x,
    output logic [11:0] shot_y,
    input  logic        shot_ready,
    output logic [15:0] shot_count
);

    localparam logic [11:0] X_MAX   = 12'(SCREEN_W - 1);
    localparam logic [11:0] Y_MAX   = 12'(SCREEN_H - 1);
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] CD_LAST = 16'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        FIRE,
        WAIT_RELEASE,
        COOLDOWN
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [15:0] cnt_inc;
    logic        left_q1;
    logic        left_s;
    logic        latch;

    // Saturating increment keeps the shared counter from ever wrapping.
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        unique case (state)
            IDLE: begin
                if (left_s) begin
                    cnt_n   = 16'd0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!left_s) begin
                    state_n = IDLE;
                end else if (cnt >= DB_LAST) begin
                    latch   = 1'b1;
                    state_n = FIRE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            // Release here does not cancel; only the handshake leaves FIRE.
            FIRE: begin
                if (shot_ready) begin
                    state_n = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!left_s) begin
                    cnt_n   = 16'd0;
                    state_n = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (cnt >= CD_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            left_q1    <= 1'b0;
            left_s     <= 1'b0;
            xpos_out   <= 12'd0;
            ypos_out   <= 12'd0;
            shot_x     <= 12'd0;
            shot_y     <= 12'd0;
            shot_valid <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            left_q1  <= left_in;
            left_s   <= left_q1;
            xpos_out <= (xpos_in > X_MAX) ? X_MAX : xpos_in;
            ypos_out <= (ypos_in > Y_MAX) ? Y_MAX : ypos_in;
            // Registered state decode: no path from shot_ready to shot_valid.
            shot_valid <= (state_n == FIRE);
            if (latch) begin
                shot_x <= xpos_out;
                shot_y <= ypos_out;
            end
        end
    end

`ifdef SHOT_COUNTER_EN
    logic accept;

    assign accept = (state == FIRE) && shot_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shot_count <= 16'd0;
        end else if (accept && (shot_count != 16'hFFFF)) begin
            shot_count <= shot_count + 16'd1;
        end
    end
`else
    assign shot_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mouse_shot_ctl.sv
// tb_mouse_shot_ctl: directed and randomized checks of mouse_shot_ctl
// against a behavioural model of the shot rules.

module tb_mouse_shot_ctl;

    localparam int W = 1024;
    localparam int H = 768;
    localparam int D = 16;
    localparam int C = 64;
`ifdef SHOT_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;
    logic        left_in;
    logic [11:0] xpos_out;
    logic [11:0] ypos_out;
    logic        shot_valid;
    logic [11:0] shot_x;
    logic [11:0] shot_y;
    logic        shot_ready;
    logic [15:0] shot_count;

    always #5 clk = ~clk;

    mouse_shot_ctl #(
        .SCREEN_W(W),
        .SCREEN_H(H),
        .DEBOUNCE_CYCLES(D),
        .COOLDOWN_CYCLES(C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .xpos_in(xpos_in),
        .ypos_in(ypos_in),
        .left_in(left_in),
        .xpos_out(xpos_out),
        .ypos_out(ypos_out),
        .shot_valid(shot_valid),
        .shot_x(shot_x),
        .shot_y(shot_y),
        .shot_ready(shot_ready),
        .shot_count(shot_count)
    );

    int tests = 0;
    int fails = 0;
    int hs    = 0;

    // Reference model: button seen two cycles late; a press must last D
    // cycles to arm a shot; after the shot is taken the button must be
    // released, then C cycles of dead time follow.
    bit [1:0] m_sync;
    bit       m_pend;
    bit       m_hold;
    int       m_cool;
    int       m_run;
    int       m_xo, m_yo, m_sx, m_sy;
    int       m_count;

    function automatic int exp_count();
        return CNT_EN ? m_count : 0;
    endfunction

    task automatic step();
        bit ls;
        if (rst_n && shot_valid && shot_ready) hs++;
        if (!rst_n) begin
            m_sync = 2'b00; m_pend = 0; m_hold = 0; m_cool = 0;
            m_run = -1; m_xo = 0; m_yo = 0; m_sx = 0; m_sy = 0;
            m_count = 0;
        end else begin
            ls = m_sync[1];
            if (m_pend) begin
                if (shot_ready) begin
                    m_pend = 0;
                    m_hold = 1;
                    if (m_count < 65535) m_count++;
                end
            end else if (m_hold) begin
                if (!ls) begin
                    m_hold = 0;
                    m_cool = C;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (m_run < 0) begin
                if (ls) m_run = 0;
            end else if (!ls) begin
                m_run = -1;
            end else if (m_run == D - 1) begin
                m_pend = 1;
                m_sx = m_xo;
                m_sy = m_yo;
                m_run = -1;
            end else begin
                m_run++;
            end
            m_sync = {m_sync[0], left_in};
            m_xo = (int'(xpos_in) > W - 1) ? W - 1 : int'(xpos_in);
            m_yo = (int'(ypos_in) > H - 1) ? H - 1 : int'(ypos_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        xpos_in = 12'($urandom_range(0, 4095));
        ypos_in = 12'($urandom_range(0, 4095));
        left_in = 1; shot_ready = 1;
        step(); step();
        tests++;
        if (xpos_out !== 0 || ypos_out !== 0 || shot_valid !== 0 ||
            shot_x !== 0 || shot_y !== 0 || shot_count !== 0) begin
            fails++;
            $display("FAIL reset: x=%0d y=%0d v=%0b sx=%0d sy=%0d cnt=%0d, need all 0",
                     xpos_out, ypos_out, shot_valid, shot_x, shot_y, shot_count);
        end
        left_in = 0; shot_ready = 0;
        rst_n = 1;
        step();
        tests++;
        if (shot_valid !== 0) begin
            fails++;
            $display("FAIL reset_release: valid=%0b need 0", shot_valid);
        end
    endtask

    task automatic test_clamp();
        xpos_in = 12'd1500; ypos_in = 12'd900;
        step();
        tests++;
        if (xpos_out !== 12'd1023 || ypos_out !== 12'd767) begin
            fails++;
            $display("FAIL clamp_hi: got (%0d,%0d) need (1023,767)", xpos_out, ypos_out);
        end
        xpos_in = 12'd512; ypos_in = 12'd767;
        step();
        tests++;
        if (xpos_out !== 12'd512 || ypos_out !== 12'd767) begin
            fails++;
            $display("FAIL clamp_pass: got (%0d,%0d) need (512,767)", xpos_out, ypos_out);
        end
        xpos_in = 12'd1023; ypos_in = 12'd768;
        step();
        tests++;
        if (xpos_out !== 12'd1023 || ypos_out !== 12'd767) begin
            fails++;
            $display("FAIL clamp_edge: got (%0d,%0d) need (1023,767)", xpos_out, ypos_out);
        end
        for (int i = 0; i < 20; i++) begin
            xpos_in = 12'($urandom_range(0, 4095));
            ypos_in = 12'($urandom_range(0, 4095));
            step();
            tests++;
            if (xpos_out !== 12'(m_xo) || ypos_out !== 12'(m_yo)) begin
                fails++;
                $display("FAIL clamp_rand: got (%0d,%0d) need (%0d,%0d)",
                         xpos_out, ypos_out, m_xo, m_yo);
            end
        end
    endtask

    task automatic test_glitch();
        int seen = 0;
        shot_ready = 1;
        left_in = 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) left_in = 0;
            step();
            if (shot_valid !== 0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL glitch: valid high %0d cycles need 0", seen);
        end
        tests++;
        if (m_pend || m_run >= 0) begin
            fails++;
            $display("FAIL glitch_model: model not idle after short press");
        end
    endtask

    task automatic test_normal_shot();
        int at = -1;
        int bad = 0;
        xpos_in = 12'd300; ypos_in = 12'd200;
        shot_ready = 1;
        step();
        hs = 0;
        left_in = 1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (shot_valid === 1 && at < 0) begin
                at = i;
                if (shot_x !== 12'd300 || shot_y !== 12'd200) bad++;
            end
            if (shot_valid !== m_pend) bad++;
        end
        left_in = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (shot_valid !== m_pend) bad++;
        end
        tests++;
        if (at != 2 + D + 1) begin
            fails++;
            $display("FAIL shot_latency: valid after %0d cycles need %0d", at, 2 + D + 1);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL shot_data: %0d bad cycles need 0", bad);
        end
        tests++;
        if (hs != 1) begin
            fails++;
            $display("FAIL shot_handshakes: got %0d need 1", hs);
        end
        tests++;
        if (shot_count !== 16'(CNT_EN ? 1 : 0)) begin
            fails++;
            $display("FAIL shot_count: got %0d need %0d", shot_count, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_backpressure();
        int got = 0;
        int bad = 0;
        xpos_in = 12'd300; ypos_in = 12'd200;
        shot_ready = 0;
        step();
        hs = 0;
        left_in = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (shot_valid === 1) got = 1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL bp_timeout: valid=%0b need 1 within 40 cycles", shot_valid);
        end
        xpos_in = 12'd700; ypos_in = 12'd400;
        left_in = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (shot_valid !== 1 || shot_x !== 12'd300 || shot_y !== 12'd200) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: %0d bad cycles, last v=%0b (%0d,%0d) need 1 (300,200)",
                     bad, shot_valid, shot_x, shot_y);
        end
        shot_ready = 1;
        step();
        shot_ready = 0;
        tests++;
        if (shot_valid !== 0 || hs != 1) begin
            fails++;
            $display("FAIL bp_accept: valid=%0b hs=%0d need 0 and 1", shot_valid, hs);
        end
        for (int i = 0; i < 100; i++) step();
        tests++;
        if (shot_valid !== 0 || hs != 1) begin
            fails++;
            $display("FAIL bp_after: valid=%0b hs=%0d need 0 and 1", shot_valid, hs);
        end
    endtask

    task automatic test_hold_cooldown();
        hs = 0;
        shot_ready = 1;
        left_in = 1;
        for (int i = 0; i < 1000; i++) step();
        tests++;
        if (hs != 1) begin
            fails++;
            $display("FAIL hold_once: handshakes %0d need 1", hs);
        end
        left_in = 0;
        for (int i = 0; i < 10; i++) step();
        left_in = 1;
        for (int i = 0; i < 20; i++) step();
        left_in = 0;
        for (int i = 0; i < 40; i++) step();
        tests++;
        if (hs != 1) begin
            fails++;
            $display("FAIL cooldown_ignore: handshakes %0d need 1", hs);
        end
        left_in = 1;
        for (int i = 0; i < 40; i++) step();
        left_in = 0;
        for (int i = 0; i < 100; i++) step();
        tests++;
        if (hs != 2) begin
            fails++;
            $display("FAIL cooldown_rearm: handshakes %0d need 2", hs);
        end
    endtask

    task automatic test_random();
        int run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                left_in = ~left_in;
                run = $urandom_range(1, 80);
            end
            run--;
            shot_ready = ($urandom_range(0, 3) == 0);
            xpos_in = 12'($urandom_range(0, 4095));
            ypos_in = 12'($urandom_range(0, 4095));
            step();
            tests++;
            if (xpos_out !== 12'(m_xo) || ypos_out !== 12'(m_yo) ||
                shot_valid !== m_pend || shot_count !== 16'(exp_count()) ||
                (m_pend && (shot_x !== 12'(m_sx) || shot_y !== 12'(m_sy)))) begin
                fails++;
                $display("FAIL random c%0d: x=%0d y=%0d v=%0b sx=%0d sy=%0d n=%0d need x=%0d y=%0d v=%0b sx=%0d sy=%0d n=%0d",
                         i, xpos_out, ypos_out, shot_valid, shot_x, shot_y, shot_count,
                         m_xo, m_yo, m_pend, m_sx, m_sy, exp_count());
            end
        end
        left_in = 0;
        shot_ready = 1;
        for (int i = 0; i < 200; i++) step();
    endtask

    task automatic test_reset_in_fire();
        int got = 0;
        int bad = 0;
        shot_ready = 0;
        xpos_in = 12'd300; ypos_in = 12'd200;
        left_in = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (shot_valid === 1) got = 1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL rf_timeout: valid=%0b need 1", shot_valid);
        end
        left_in = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        tests++;
        if (shot_valid !== 0 || shot_x !== 0 || shot_y !== 0 || shot_count !== 0) begin
            fails++;
            $display("FAIL rf_clear: v=%0b sx=%0d sy=%0d n=%0d need all 0",
                     shot_valid, shot_x, shot_y, shot_count);
        end
        hs = 0;
        shot_ready = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (shot_valid !== 0) bad++;
        end
        tests++;
        if (bad != 0 || hs != 0) begin
            fails++;
            $display("FAIL rf_discard: valid cycles %0d hs %0d need 0 and 0", bad, hs);
        end
    endtask

    initial begin
        rst_n = 0;
        xpos_in = 0; ypos_in = 0;
        left_in = 0; shot_ready = 0;
        test_reset();
        test_clamp();
        test_glitch();
        test_normal_shot();
        test_backpressure();
        test_hold_cooldown();
        test_random();
        test_reset_in_fire();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mouse_shot_ctl.md
MOUSE_SHOT_CTL -- requirements
Module: mouse_shot_ctl

Interface
REQ-001 Parameter SCREEN_W, default 1024, horizontal pixel count; x clamp limit is SCREEN_W-1.
REQ-002 Parameter SCREEN_H, default 768, vertical pixel count; y clamp limit is SCREEN_H-1.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, legal range 1..65535; cycles the button must stay pressed to register a shot.
REQ-004 Parameter COOLDOWN_CYCLES, default 64, legal range 1..65535; dead time after button release.
REQ-005 clk  input  1  the single system clock; every flop is on its rising edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 xpos_in  input  12  cursor x, already synchronised to clk.
REQ-008 ypos_in  input  12  cursor y, already synchronised to clk.
REQ-009 left_in  input  1  raw left mouse button, asynchronous to clk.
REQ-010 xpos_out  output  12  clamped, registered cursor x.
REQ-011 ypos_out  output  12  clamped, registered cursor y.
REQ-012 shot_valid  output  1  a shot event is pending.
REQ-013 shot_x  output  12  x of the pending shot.
REQ-014 shot_y  output  12  y of the pending shot.
REQ-015 shot_ready  input  1  the consumer accepts the pending shot.
REQ-016 shot_count  output  16  number of accepted shots (see Configuration).

Function
REQ-017 The block SHALL pass left_in through a two-flop synchroniser (left_s) before any use; this adds 2 cycles of latency.
REQ-018 The block SHALL set xpos_out = min(xpos_in, SCREEN_W-1) and ypos_out = min(ypos_in, SCREEN_H-1), compared unsigned and registered, with 1-cycle latency.
REQ-019 The FSM SHALL have exactly these states: IDLE, DEBOUNCE, FIRE, WAIT_RELEASE and COOLDOWN.
REQ-020 IDLE: when left_s=1, the FSM SHALL clear the counter and go to DEBOUNCE.
REQ-021 DEBOUNCE: when left_s=0, the FSM SHALL return to IDLE.
REQ-022 DEBOUNCE: otherwise the counter SHALL increment; when it reaches DEBOUNCE_CYCLES-1 with left_s=1, the FSM SHALL latch xpos_out/ypos_out into shot_x/shot_y and go to FIRE.
REQ-023 FIRE: shot_valid SHALL be 1, and shot_x/shot_y SHALL stay stable until a handshake.
REQ-024 Handshake: a shot is accepted on a cycle with shot_valid=1 and shot_ready=1; the FSM SHALL then go to WAIT_RELEASE.
REQ-025 shot_ready while the FSM is not in FIRE SHALL be ignored.
REQ-026 A button release during FIRE SHALL NOT cancel the pending shot.
REQ-027 WAIT_RELEASE: when left_s=0, the FSM SHALL clear the counter and go to COOLDOWN; a held button SHALL never retrigger a shot.
REQ-028 COOLDOWN: the counter SHALL increment and the FSM SHALL go to IDLE when it reaches COOLDOWN_CYCLES-1; presses during COOLDOWN SHALL be ignored.
REQ-029 shot_valid SHALL be a registered decode of the FSM state, with no combinational path from shot_ready.
REQ-030 There SHALL be a single shared 16-bit counter; it SHALL never wrap in any state.

Reset
REQ-031 With rst_n=0 at a clock edge, the FSM SHALL enter IDLE and clear to 0: the counter, both synchroniser flops, xpos_out, ypos_out, shot_x, shot_y, shot_valid and shot_count.
REQ-032 A reset asserted mid-operation, including in FIRE with a shot pending, SHALL discard the pending shot with no handshake.

Configuration
REQ-033 Macro SHOT_COUNTER_EN defined: shot_count SHALL increment by 1 on each accepted handshake and saturate at 16'hFFFF.
REQ-034 Macro SHOT_COUNTER_EN undefined: the port SHALL remain, shot_count SHALL be tied to 16'h0000, and no counter logic SHALL be synthesised.

Verification
REQ-035 Clamp: xpos_in=1500, ypos_in=900 -> one cycle later xpos_out=1023, ypos_out=767; xpos_in=512 -> xpos_out=512.
REQ-036 Glitch rejection: left_in high for 10 cycles (DEBOUNCE_CYCLES=16) -> shot_valid never asserts, FSM back in IDLE.
REQ-037 Normal shot: cursor (300,200), left_in held 40 cycles, shot_ready=1 -> shot_valid asserts within 2+16+1 cycles of the press, shot_x=300, shot_y=200, exactly one handshake, shot_count=1 if SHOT_COUNTER_EN is defined.
REQ-038 Backpressure: shot_ready=0 for 50 cycles while the cursor moves to (700,400) -> shot_valid stays 1, shot_x/shot_y stay (300,200), handshake on the first cycle shot_ready=1.
REQ-039 Hold/cooldown: button held 1000 cycles -> exactly one shot; a second press 10 cycles after release (COOLDOWN_CYCLES=64) -> no shot; a press after 70 cycles -> a second shot.
REQ-040 Reset in FIRE: rst_n=0 for one cycle while shot_valid=1 -> next cycle shot_valid=0, shot_x=0, shot_count=0, FSM in IDLE.
